// File: rtl/decode_issue_stage.sv
// Decode/issue stage in front of the 8 x 8-bit register file.
// Decodes 16-bit instructions, tracks in-flight destination registers and holds back any
// instruction whose source is still being written (RAW interlock), issuing a bubble instead.
// Optional feature macro: DEC_HALT_EN (opcode F halts the stage until reset).
module decode_issue_stage #(
  parameter int unsigned WB_LAT = 3,
  parameter int unsigned IW     = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] instr_in,
  input  logic          instr_valid,
  output logic          instr_ready,
  output logic [2:0]    RA,
  output logic [2:0]    RB,
  output logic [2:0]    RDo,
  output logic          RegWrite,
  output logic [3:0]    alu_op,
  output logic [7:0]    imm,
  output logic          use_imm,
  output logic          mem_read,
  output logic          mem_write,
  output logic          valid_out,
  output logic          halted
);

  localparam logic [3:0] OpNop = 4'h0;
  localparam logic [3:0] OpAdd = 4'h1;
  localparam logic [3:0] OpSub = 4'h2;
  localparam logic [3:0] OpAnd = 4'h3;
  localparam logic [3:0] OpOr  = 4'h4;
  localparam logic [3:0] OpXor = 4'h5;
  localparam logic [3:0] OpShl = 4'h6;
  localparam logic [3:0] OpShr = 4'h7;
  localparam logic [3:0] OpLdi = 4'h8;
  localparam logic [3:0] OpLd  = 4'h9;
  localparam logic [3:0] OpSt  = 4'hA;

  // The oldest entry retires at the coming edge, so its write is already visible to a
  // consumer issued at that edge; only the younger entries can cause a stall.
  localparam logic [WB_LAT-1:0] LiveMask = {WB_LAT{1'b1}} >> 1;

  // Instruction fields
  logic [3:0] op;
  logic [2:0] f_rd, f_ra, f_rb;
  logic [7:0] f_imm;

  assign op    = instr_in[15:12];
  assign f_rd  = instr_in[11:9];
  assign f_ra  = instr_in[8:6];
  assign f_rb  = instr_in[5:3];
  assign f_imm = instr_in[7:0];

  // Decoded controls
  logic [3:0] dec_alu;
  logic       dec_wr_op, dec_use_imm, dec_mem_rd, dec_mem_wr, dec_use_a, dec_use_b;
  logic       dec_rw;

  // Opcode decode; B..F fall through as an illegal NOP with all controls clear
  always_comb begin
    dec_alu     = 4'h0;
    dec_wr_op   = 1'b0;
    dec_use_imm = 1'b0;
    dec_mem_rd  = 1'b0;
    dec_mem_wr  = 1'b0;
    dec_use_a   = 1'b0;
    dec_use_b   = 1'b0;
    case (op)
      OpNop: ;
      OpAdd, OpSub, OpAnd, OpOr, OpXor, OpShl, OpShr: begin
        dec_alu   = op;
        dec_wr_op = 1'b1;
        dec_use_a = 1'b1;
        dec_use_b = 1'b1;
      end
      OpLdi: begin
        dec_alu     = op;
        dec_wr_op   = 1'b1;
        dec_use_imm = 1'b1;
      end
      OpLd: begin
        dec_alu    = op;
        dec_wr_op  = 1'b1;
        dec_mem_rd = 1'b1;
        dec_use_a  = 1'b1;
      end
      OpSt: begin
        dec_alu    = op;
        dec_mem_wr = 1'b1;
        dec_use_a  = 1'b1;
        dec_use_b  = 1'b1;
      end
      default: ;
    endcase
  end

  // r0 is hardwired to zero, so writing it is dropped entirely
  assign dec_rw = dec_wr_op & (f_rd != 3'd0);

  // Destination scoreboard: one {valid, rd} slot per edge of write-back latency
  logic [WB_LAT-1:0] sb_v_q, sb_v_d;
  logic [2:0]        sb_rd_q [WB_LAT];
  logic [2:0]        sb_rd_d [WB_LAT];
  logic [WB_LAT-1:0] match;
  logic              stall, accept, issue;

  // Per-entry RAW match against the used, nonzero sources of the presented instruction
  always_comb begin
    match = '0;
    for (int i = 0; i < int'(WB_LAT); i++) begin
      match[i] = sb_v_q[i] &&
                 ((dec_use_a && (f_ra != 3'd0) && (sb_rd_q[i] == f_ra)) ||
                  (dec_use_b && (f_rb != 3'd0) && (sb_rd_q[i] == f_rb)));
    end
  end

  assign stall       = instr_valid & (|(match & LiveMask));
  assign instr_ready = ~stall & ~halted;
  assign accept      = instr_valid & instr_ready;

`ifdef DEC_HALT_EN
  localparam logic [3:0] OpHalt = 4'hF;

  logic dec_halt;
  logic halted_q;

  assign dec_halt = (op == OpHalt);
  // HALT is consumed but leaves a bubble downstream
  assign issue    = accept & ~dec_halt;
  assign halted   = halted_q;

  // Sticky halt flag, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halted_q <= 1'b0;
    end else if (accept && dec_halt) begin
      halted_q <= 1'b1;
    end
  end
`else
  assign issue  = accept;
  assign halted = 1'b0;
`endif

  // Scoreboard shift: new entry at slot 0, oldest falls off the end
  always_comb begin
    sb_v_d     = '0;
    sb_v_d[0]  = issue & dec_rw;
    sb_rd_d[0] = (issue && dec_rw) ? f_rd : 3'd0;
    for (int i = 1; i < int'(WB_LAT); i++) begin
      sb_v_d[i]  = sb_v_q[i-1];
      sb_rd_d[i] = sb_rd_q[i-1];
    end
  end

  // Scoreboard state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_v_q <= '0;
      for (int i = 0; i < int'(WB_LAT); i++) begin
        sb_rd_q[i] <= 3'd0;
      end
    end else begin
      sb_v_q <= sb_v_d;
      for (int i = 0; i < int'(WB_LAT); i++) begin
        sb_rd_q[i] <= sb_rd_d[i];
      end
    end
  end

  // Issue registers
  logic       valid_q, rw_q, use_imm_q, mem_rd_q, mem_wr_q;
  logic [3:0] alu_q;
  logic [2:0] ra_q, rb_q, rd_q;
  logic [7:0] imm_q;

  // Load decoded instruction on issue; otherwise a bubble that keeps the register indices
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      rw_q      <= 1'b0;
      alu_q     <= 4'h0;
      use_imm_q <= 1'b0;
      mem_rd_q  <= 1'b0;
      mem_wr_q  <= 1'b0;
      ra_q      <= 3'd0;
      rb_q      <= 3'd0;
      rd_q      <= 3'd0;
      imm_q     <= 8'h00;
    end else if (issue) begin
      valid_q   <= 1'b1;
      rw_q      <= dec_rw;
      alu_q     <= dec_alu;
      use_imm_q <= dec_use_imm;
      mem_rd_q  <= dec_mem_rd;
      mem_wr_q  <= dec_mem_wr;
      ra_q      <= f_ra;
      rb_q      <= f_rb;
      rd_q      <= f_rd;
      imm_q     <= f_imm;
    end else begin
      valid_q   <= 1'b0;
      rw_q      <= 1'b0;
      alu_q     <= 4'h0;
      use_imm_q <= 1'b0;
      mem_rd_q  <= 1'b0;
      mem_wr_q  <= 1'b0;
    end
  end

  assign valid_out = valid_q;
  assign RegWrite  = rw_q;
  assign alu_op    = alu_q;
  assign use_imm   = use_imm_q;
  assign mem_read  = mem_rd_q;
  assign mem_write = mem_wr_q;
  assign RA        = ra_q;
  assign RB        = rb_q;
  assign RDo       = rd_q;
  assign imm       = imm_q;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Testbench for decode_issue_stage (WB_LAT = 3): table of single-instruction decode vectors
// plus hand-written hazard, reset and halt sequences, checked through an expected-output queue.
module tb_decode_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr_in;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  RA, RB, RDo;
  logic        RegWrite;
  logic [3:0]  alu_op;
  logic [7:0]  imm;
  logic        use_imm, mem_read, mem_write, valid_out, halted;

  decode_issue_stage #(
    .WB_LAT (3),
    .IW     (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_in    (instr_in),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .RA          (RA),
    .RB          (RB),
    .RDo         (RDo),
    .RegWrite    (RegWrite),
    .alu_op      (alu_op),
    .imm         (imm),
    .use_imm     (use_imm),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .valid_out   (valid_out),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  // {valid, RegWrite, alu_op, use_imm, mem_read, mem_write, RA, RB, RDo, imm}
  typedef struct packed {
    logic       vld;
    logic       rw;
    logic [3:0] alu;
    logic       ui;
    logic       mr;
    logic       mw;
    logic [2:0] ra;
    logic [2:0] rb;
    logic [2:0] rd;
    logic [7:0] imm;
  } out_t;

  typedef struct {
    logic [15:0] ins;
    logic [8:0]  ctl;
  } vec_t;

  out_t expq[$];
  vec_t tbl[14];
  int   checks = 0;
  int   errors = 0;

  // Register fields currently expected on the outputs (held across bubbles)
  logic [2:0] h_ra = 3'd0, h_rb = 3'd0, h_rd = 3'd0;
  logic [7:0] h_imm = 8'h00;

  task automatic chk1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic chk_out(input string name);
    out_t got, exp;
    got = {valid_out, RegWrite, alu_op, use_imm, mem_read, mem_write, RA, RB, RDo, imm};
    checks++;
    if (expq.size() == 0) begin
      errors++;
      $display("FAIL %s: got %h expected <queue empty>", name, got);
    end else begin
      exp = expq.pop_front();
      if (got !== exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", name, got, exp);
      end
    end
  endtask

  // One cycle: drive at negedge, check ready, queue expected result, compare after the edge.
  // ctl = {valid, RegWrite, alu_op, use_imm, mem_read, mem_write} if the instruction issues;
  // ctl[8]=0 with an accept means the instruction is consumed but leaves a bubble.
  task automatic step(input logic v, input logic [15:0] ins, input logic exp_rdy,
                      input logic [8:0] ctl, input string name);
    out_t e;
    @(negedge clk);
    instr_valid = v;
    instr_in    = ins;
    #1;
    chk1({name, ".ready"}, instr_ready, exp_rdy);
    if (v && exp_rdy && ctl[8]) begin
      h_ra  = ins[8:6];
      h_rb  = ins[5:3];
      h_rd  = ins[11:9];
      h_imm = ins[7:0];
      e = {ctl, h_ra, h_rb, h_rd, h_imm};
    end else begin
      e = {9'b0, h_ra, h_rb, h_rd, h_imm};
    end
    expq.push_back(e);
    @(posedge clk);
    #1;
    chk_out(name);
  endtask

  task automatic idle2();
    step(1'b0, 16'h0000, 1'b1, 9'b0, "idle");
    step(1'b0, 16'h0000, 1'b1, 9'b0, "idle");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{16'h0000, 9'b1_0_0000_000};  // NOP
    tbl[1]  = '{16'h1298, 9'b1_1_0001_000};  // ADD r1,r2,r3
    tbl[2]  = '{16'h2E48, 9'b1_1_0010_000};  // SUB r7,r1,r1
    tbl[3]  = '{16'h3628, 9'b1_1_0011_000};  // AND r3,r0,r5
    tbl[4]  = '{16'h4050, 9'b1_0_0100_000};  // OR  r0,r1,r2 (rd=0: no write)
    tbl[5]  = '{16'h5DB0, 9'b1_1_0101_000};  // XOR r6,r6,r6
    tbl[6]  = '{16'h6A98, 9'b1_1_0110_000};  // SHL r5,r2,r3
    tbl[7]  = '{16'h7848, 9'b1_1_0111_000};  // SHR r4,r1,r1
    tbl[8]  = '{16'h825A, 9'b1_1_1000_100};  // LDI r1,0x5A
    tbl[9]  = '{16'h94C0, 9'b1_1_1001_010};  // LD  r2,[r3]
    tbl[10] = '{16'hA128, 9'b1_0_1010_001};  // ST  [r4],r5
    tbl[11] = '{16'hB6FF, 9'b1_0_0000_000};  // illegal
    tbl[12] = '{16'hC123, 9'b1_0_0000_000};  // illegal
    tbl[13] = '{16'hDE00, 9'b1_0_0000_000};  // illegal

    // Reset state
    rst = 1'b1;
    instr_valid = 1'b0;
    instr_in = 16'h0000;
    #2;
    expq.push_back('0);
    chk_out("reset_outputs");
    chk1("reset_ready", instr_ready, 1'b1);
    chk1("reset_halted", halted, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Decode table, each vector isolated so no hazards arise
    for (int i = 0; i < 14; i++) begin
      step(1'b1, tbl[i].ins, 1'b1, tbl[i].ctl, $sformatf("vec%0d", i));
      idle2();
    end

    // Back-to-back independent ADDs
    step(1'b1, 16'h1298, 1'b1, 9'b1_1_0001_000, "b2b_add0");
    step(1'b1, 16'h1970, 1'b1, 9'b1_1_0001_000, "b2b_add1");
    idle2();

    // LDI r1 then dependent ADD r2,r1,r1: two stalled cycles, issue at 3rd edge
    step(1'b1, 16'h825A, 1'b1, 9'b1_1_1000_100, "raw_ldi");
    step(1'b1, 16'h1448, 1'b0, 9'b1_1_0001_000, "raw_stall1");
    step(1'b1, 16'h1448, 1'b0, 9'b1_1_0001_000, "raw_stall2");
    step(1'b1, 16'h1448, 1'b1, 9'b1_1_0001_000, "raw_issue");
    idle2();

    // LD r3 then ST [r0],r3: hazard through rb only
    step(1'b1, 16'h9640, 1'b1, 9'b1_1_1001_010, "rb_ld");
    step(1'b1, 16'hA018, 1'b0, 9'b1_0_1010_001, "rb_stall1");
    step(1'b1, 16'hA018, 1'b0, 9'b1_0_1010_001, "rb_stall2");
    step(1'b1, 16'hA018, 1'b1, 9'b1_0_1010_001, "rb_issue");
    idle2();

    // LDI has no sources: ra field matching an in-flight rd does not stall
    step(1'b1, 16'h8800, 1'b1, 9'b1_1_1000_100, "ldi_r4");
    step(1'b1, 16'h8B00, 1'b1, 9'b1_1_1000_100, "ldi_nosrc");
    idle2();

    // LDI r0 writes nothing; ADD r2,r0,r0 issues next edge
    step(1'b1, 16'h80FF, 1'b1, 9'b1_0_1000_100, "ldi_r0");
    step(1'b1, 16'h1400, 1'b1, 9'b1_1_0001_000, "add_r0src");
    idle2();

    // Illegal opcode with rd=r2 makes no scoreboard entry
    step(1'b1, 16'hE555, 1'b1, 9'b1_0_0000_000, "illegal_e");
    step(1'b1, 16'h1290, 1'b1, 9'b1_1_0001_000, "after_illegal");
    idle2();

    // Asynchronous reset in the middle of a stall
    step(1'b1, 16'h8600, 1'b1, 9'b1_1_1000_100, "rst_ldi");
    @(negedge clk);
    instr_valid = 1'b1;
    instr_in    = 16'h12D8;  // ADD r1,r3,r3
    #1;
    chk1("rst_prestall_ready", instr_ready, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    h_ra = 3'd0; h_rb = 3'd0; h_rd = 3'd0; h_imm = 8'h00;
    expq.push_back('0);
    chk_out("rst_async_outputs");
    chk1("rst_async_ready", instr_ready, 1'b1);
    chk1("rst_async_halted", halted, 1'b0);
    #1;
    rst = 1'b0;
    h_ra = 3'd3; h_rb = 3'd3; h_rd = 3'd1; h_imm = 8'hD8;
    expq.push_back({9'b1_1_0001_000, h_ra, h_rb, h_rd, h_imm});
    @(posedge clk);
    #1;
    chk_out("rst_first_accept");
    idle2();

`ifdef DEC_HALT_EN
    step(1'b1, 16'hF000, 1'b1, 9'b0, "halt_accept");
    chk1("halt_set", halted, 1'b1);
    step(1'b1, 16'h1298, 1'b0, 9'b1_1_0001_000, "halt_blocked");
    chk1("halt_held", halted, 1'b1);
    @(negedge clk);
    instr_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk1("halt_rst_clear", halted, 1'b0);
    chk1("halt_rst_ready", instr_ready, 1'b1);
    rst = 1'b0;
    h_ra = 3'd0; h_rb = 3'd0; h_rd = 3'd0; h_imm = 8'h00;
    step(1'b1, 16'h1298, 1'b1, 9'b1_1_0001_000, "halt_after_rst");
`else
    step(1'b1, 16'hF000, 1'b1, 9'b1_0_0000_000, "op_f_nop");
    chk1("op_f_halted", halted, 1'b0);
    step(1'b1, 16'h1298, 1'b1, 9'b1_1_0001_000, "op_f_next");
`endif
    idle2();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
